// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the 1x3 router ingress control.
//   - state_e     : 3-bit binary encoding of the eight FSM states
//   - ADDR0..2    : destination codes of the three output FIFOs
//   - ADDR_INVALID: destination code that is never routed
//   - sel_flag()  : picks the flag belonging to one destination
package router_pkg;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    // Per-FIFO flag of destination a; the invalid code selects nothing.
    function automatic logic sel_flag(input logic [2:0] flags, input logic [1:0] a);
        case (a)
            ADDR0:   return flags[0];
            ADDR1:   return flags[1];
            ADDR2:   return flags[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_fsm.sv
// router_fsm: control FSM of the 1x3 router ingress path.
// Decodes the header destination, waits for the selected FIFO to drain,
// then steps the register datapath through header/payload loads, FIFO-full
// hold and parity capture/check, gating FIFO writes and stalling the source.
// Ports:
//   clk, rst (async, active low)
//   pktvalid, din          : source byte valid and destination field
//   fifofull               : full flag of the selected FIFO
//   fifoempty0..2          : empty flags of the three output FIFOs
//   softrst0..2            : read-timeout soft resets of the three FIFOs
//   paritydone, lowpktvalid: status from the register block
//   detectadd, lfdstate, ldstate, fullstate, lafstate : state strobes
//   rstintreg              : active-low clear of register internal flags
//   writeenbreg            : FIFO write enable
//   busy                   : source must hold its current byte
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDRW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pktvalid,
    input  logic [ADDRW-1:0] din,
    input  logic             fifofull,
    input  logic             fifoempty0,
    input  logic             fifoempty1,
    input  logic             fifoempty2,
    input  logic             softrst0,
    input  logic             softrst1,
    input  logic             softrst2,
    input  logic             paritydone,
    input  logic             lowpktvalid,
    output logic             detectadd,
    output logic             lfdstate,
    output logic             ldstate,
    output logic             fullstate,
    output logic             lafstate,
    output logic             rstintreg,
    output logic             writeenbreg,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [ADDRW-1:0] addr_q,  addr_d;

    logic [2:0] empty_vec;
    logic [2:0] softrst_vec;
    logic       hdr_valid;

    assign empty_vec   = {fifoempty2, fifoempty1, fifoempty0};
    assign softrst_vec = {softrst2, softrst1, softrst0};
    assign hdr_valid   = pktvalid && (din != ADDR_INVALID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    addr_d  = din;
                    state_d = sel_flag(empty_vec, din) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_flag(empty_vec, addr_q)) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifofull)       state_d = FIFO_FULL_STATE;
                else if (!pktvalid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifofull) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (paritydone)       state_d = DECODE_ADDRESS;
                else if (lowpktvalid) state_d = LOAD_PARITY;
                else                  state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifofull ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A read timeout on the FIFO this packet targets aborts the packet,
        // overriding whatever the state would otherwise do.
        if (state_q != DECODE_ADDRESS && sel_flag(softrst_vec, addr_q))
            state_d = DECODE_ADDRESS;
    end

    // Moore outputs; reset forces DECODE_ADDRESS asynchronously, so busy and
    // writeenbreg fall with rst. rstintreg also looks at rst directly.
    always_comb begin
        detectadd   = (state_q == DECODE_ADDRESS);
        lfdstate    = (state_q == LOAD_FIRST_DATA);
        ldstate     = (state_q == LOAD_DATA);
        fullstate   = (state_q == FIFO_FULL_STATE);
        lafstate    = (state_q == LOAD_AFTER_FULL);
        writeenbreg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                      (state_q == LOAD_AFTER_FULL);
        busy        = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
        rstintreg   = rst && (state_q != CHECK_PARITY_ERROR);
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural packet-phase model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pktvalid = 1'b0;
    logic [1:0] din = 2'd0;
    logic       fifofull = 1'b0;
    logic       fifoempty0 = 1'b1, fifoempty1 = 1'b1, fifoempty2 = 1'b1;
    logic       softrst0 = 1'b0, softrst1 = 1'b0, softrst2 = 1'b0;
    logic       paritydone = 1'b0, lowpktvalid = 1'b0;
    logic       detectadd, lfdstate, ldstate, fullstate, lafstate;
    logic       rstintreg, writeenbreg, busy;

    always #5 clk = ~clk;

    router_fsm #(.ADDRW(2)) dut (
        .clk(clk), .rst(rst), .pktvalid(pktvalid), .din(din),
        .fifofull(fifofull),
        .fifoempty0(fifoempty0), .fifoempty1(fifoempty1), .fifoempty2(fifoempty2),
        .softrst0(softrst0), .softrst1(softrst1), .softrst2(softrst2),
        .paritydone(paritydone), .lowpktvalid(lowpktvalid),
        .detectadd(detectadd), .lfdstate(lfdstate), .ldstate(ldstate),
        .fullstate(fullstate), .lafstate(lafstate), .rstintreg(rstintreg),
        .writeenbreg(writeenbreg), .busy(busy)
    );

    // {detectadd, lfdstate, ldstate, fullstate, lafstate, rstintreg, writeenbreg, busy}
    logic [7:0] act;
    assign act = {detectadd, lfdstate, ldstate, fullstate, lafstate,
                  rstintreg, writeenbreg, busy};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model: packet phase ----------------
    localparam int P_IDLE  = 10;  // waiting for a header
    localparam int P_WAIT  = 20;  // header seen, target FIFO not empty
    localparam int P_FIRST = 30;  // header byte written
    localparam int P_DATA  = 40;  // payload streaming
    localparam int P_FULL  = 50;  // stalled on full FIFO
    localparam int P_AFTER = 60;  // first cycle after full clears
    localparam int P_PAR   = 70;  // parity byte written
    localparam int P_CHK   = 80;  // parity compared

    int         ph;
    logic [1:0] m_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph     <= P_IDLE;
            m_addr <= 2'd0;
        end else begin
            logic [2:0] emp;
            logic [2:0] sr;
            emp = {fifoempty2, fifoempty1, fifoempty0};
            sr  = {softrst2, softrst1, softrst0};
            if (ph != P_IDLE && sr[m_addr]) ph <= P_IDLE;
            else if (ph == P_IDLE) begin
                if (pktvalid && din != 2'd3) begin
                    m_addr <= din;
                    ph     <= emp[din] ? P_FIRST : P_WAIT;
                end
            end
            else if (ph == P_WAIT)  ph <= emp[m_addr] ? P_FIRST : P_WAIT;
            else if (ph == P_FIRST) ph <= P_DATA;
            else if (ph == P_DATA)  ph <= fifofull ? P_FULL : (!pktvalid ? P_PAR : P_DATA);
            else if (ph == P_FULL)  ph <= fifofull ? P_FULL : P_AFTER;
            else if (ph == P_AFTER) ph <= paritydone ? P_IDLE : (lowpktvalid ? P_PAR : P_DATA);
            else if (ph == P_PAR)   ph <= P_CHK;
            else                    ph <= fifofull ? P_FULL : P_IDLE;
        end
    end

    function automatic logic [7:0] exp_out(input int p, input logic r);
        logic [7:0] v;
        if (!r) return 8'b1000_0000;
        v = 8'b0000_0100;               // rstintreg high by default
        case (p)
            P_IDLE:  v[7] = 1'b1;
            P_WAIT:  v[0] = 1'b1;
            P_FIRST: begin v[6] = 1'b1; v[0] = 1'b1; end
            P_DATA:  begin v[5] = 1'b1; v[1] = 1'b1; end
            P_FULL:  begin v[4] = 1'b1; v[0] = 1'b1; end
            P_AFTER: begin v[3] = 1'b1; v[1] = 1'b1; v[0] = 1'b1; end
            P_PAR:   begin v[1] = 1'b1; v[0] = 1'b1; end
            default: begin v[2] = 1'b0; v[0] = 1'b1; end  // parity check
        endcase
        return v;
    endfunction

    // Single compare process: every cycle, mid-period.
    always @(negedge clk) chk("cycle_outputs", act, exp_out(ph, rst));

    // Inputs change just after the falling edge; the next rising edge uses them.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    localparam logic [7:0] V_IDLE = 8'b1000_0100;
    localparam logic [7:0] V_WAIT = 8'b0000_0101;
    localparam logic [7:0] V_LFD  = 8'b0100_0101;
    localparam logic [7:0] V_LD   = 8'b0010_0110;
    localparam logic [7:0] V_FULL = 8'b0001_0101;
    localparam logic [7:0] V_LAF  = 8'b0000_1111;
    localparam logic [7:0] V_LP   = 8'b0000_0111;
    localparam logic [7:0] V_CPE  = 8'b0000_0001;
    localparam logic [7:0] V_RST  = 8'b1000_0000;

    initial begin
        repeat (2) step();
        chk("reset_outputs", act, V_RST);
        rst = 1'b1;
        step();
        chk("release_idle", act, V_IDLE);

        // Header to FIFO1, three payload cycles, parity
        pktvalid = 1'b1; din = 2'd1;
        step(); chk("p3_lfd", act, V_LFD);
        step(); chk("p3_ld1", act, V_LD);
        step(); chk("p3_ld2", act, V_LD);
        step(); chk("p3_ld3", act, V_LD); pktvalid = 1'b0;
        step(); chk("p3_lp", act, V_LP);
        step(); chk("p3_cpe", act, V_CPE);
        step(); chk("p3_idle", act, V_IDLE);

        // Short packet latency: idle again five cycles after the header
        pktvalid = 1'b1; din = 2'd0;
        step(); pktvalid = 1'b1;
        step(); pktvalid = 1'b0;
        step(); step();
        step(); chk("short_back_idle", act, V_IDLE);

        // Wait on non-empty FIFO2; FIFO0 empty flag toggles meanwhile
        pktvalid = 1'b1; din = 2'd2; fifoempty2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("wait_busy", act, V_WAIT);
            fifoempty0 = ~fifoempty0;
            if (i == 3) fifoempty2 = 1'b1;
        end
        fifoempty0 = 1'b1;
        step(); chk("wait_then_lfd", act, V_LFD);
        step(); chk("full_pre_ld", act, V_LD); fifofull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("full_hold", act, V_FULL);
            if (i == 2) fifofull = 1'b0;
        end
        step(); chk("laf", act, V_LAF);
        step(); chk("laf_to_ld", act, V_LD); fifofull = 1'b1;
        step(); chk("full_again", act, V_FULL); fifofull = 1'b0;
        step(); chk("laf2", act, V_LAF); lowpktvalid = 1'b1; pktvalid = 1'b0;
        step(); chk("laf_lowpkt_lp", act, V_LP); lowpktvalid = 1'b0;
        step(); chk("lowpkt_cpe", act, V_CPE);
        step(); chk("lowpkt_idle", act, V_IDLE);

        // paritydone out of LOAD_AFTER_FULL
        pktvalid = 1'b1; din = 2'd2;
        step(); step(); fifofull = 1'b1;
        step(); fifofull = 1'b0;
        step(); chk("laf3", act, V_LAF); paritydone = 1'b1;
        step(); chk("pdone_idle", act, V_IDLE); paritydone = 1'b0; pktvalid = 1'b0;

        // Invalid destination is ignored
        pktvalid = 1'b1; din = 2'd3;
        step(); chk("din3_stay1", act, V_IDLE);
        step(); chk("din3_stay2", act, V_IDLE);

        // Soft reset: other FIFO ignored, selected FIFO aborts
        din = 2'd0;
        step(); step(); chk("sr_ld", act, V_LD); softrst1 = 1'b1;
        step(); chk("sr1_ignored", act, V_LD); softrst1 = 1'b0; softrst0 = 1'b1;
        step(); chk("sr0_abort", act, V_IDLE); softrst0 = 1'b0; pktvalid = 1'b0;

        // Async reset mid LOAD_DATA
        pktvalid = 1'b1; din = 2'd1;
        step(); step(); chk("rst_pre_ld", act, V_LD);
        #2 rst = 1'b0;
        #1 chk("rst_async", act, V_RST);
        step(); rst = 1'b1; pktvalid = 1'b0;
        step(); chk("rst_release", act, V_IDLE);

        // Randomized traffic, compared every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            step();
            pktvalid    = ($urandom % 4) != 0;
            din         = 2'($urandom % 4);
            fifofull    = ($urandom % 5) == 0;
            fifoempty0  = ($urandom % 4) != 0;
            fifoempty1  = ($urandom % 4) != 0;
            fifoempty2  = ($urandom % 4) != 0;
            softrst0    = ($urandom % 40) == 0;
            softrst1    = ($urandom % 40) == 0;
            softrst2    = ($urandom % 40) == 0;
            paritydone  = ($urandom % 6) == 0;
            lowpktvalid = ($urandom % 6) == 0;
            if (!rst) rst = 1'b1;
            else if (($urandom % 250) == 0) rst = 1'b0;
        end
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router ingress path.
- Decodes the 2-bit destination in the header byte.
- Sequences the register datapath through header load, payload load, FIFO-full hold, parity capture and parity check, using strobes detectadd, lfdstate, ldstate, fullstate, lafstate and rstintreg.
- Gates FIFO writes, and asserts busy back to the source when the source must stall.

Parameters:
- ADDRW, 2, width of the destination field din[1:0]; code 3 is invalid.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pktvalid  in  1  source byte valid; deasserts on the parity byte
- din  in  ADDRW  destination field of the current input byte
- fifofull  in  1  full flag of the currently selected FIFO
- fifoempty0/1/2  in  1 each  empty flags of output FIFOs 0/1/2
- softrst0/1/2  in  1 each  soft-reset (read timeout) of FIFOs 0/1/2
- paritydone  in  1  register block has captured parity
- lowpktvalid  in  1  register block saw end-of-packet while full
- detectadd  out  1  high in DECODE_ADDRESS
- lfdstate  out  1  high in LOAD_FIRST_DATA
- ldstate  out  1  high in LOAD_DATA
- fullstate  out  1  high in FIFO_FULL_STATE
- lafstate  out  1  high in LOAD_AFTER_FULL
- rstintreg  out  1  active-low clear for the register's internal flags
- writeenbreg  out  1  FIFO write enable
- busy  out  1  source must hold its current byte

Behaviour:
- Moore FSM, one state register, asynchronous clear to DECODE_ADDRESS.
- A 2-bit address register addrq, asynchronous clear to 0, loads din in DECODE_ADDRESS when pktvalid=1 and din!=3.
- Reset values: detectadd=1, rstintreg=0 while rst=0, all other outputs 0.
- States and transitions:
  - DECODE_ADDRESS: pktvalid=1, din=k (k=0..2) and fifoemptyk=1 -> LOAD_FIRST_DATA. pktvalid=1, din=k and fifoemptyk=0 -> WAIT_TILL_EMPTY. din=3 or pktvalid=0 -> stay.
  - WAIT_TILL_EMPTY: fifoempty[addrq]=1 -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA: unconditionally -> LOAD_DATA (one cycle).
  - LOAD_DATA: fifofull=1 -> FIFO_FULL_STATE. Else pktvalid=0 -> LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: fifofull=1 -> stay; else -> LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL: paritydone=1 -> DECODE_ADDRESS. Else lowpktvalid=1 -> LOAD_PARITY. Else -> LOAD_DATA.
  - LOAD_PARITY: unconditionally -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifofull=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset:
  - softrst[addrq]=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle.
  - This has priority over every other transition.
  - softrst of a non-selected FIFO is ignored.
- Outputs, decoded combinationally from the state:
  - writeenbreg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
  - rstintreg = 0 in CHECK_PARITY_ERROR or while rst=0; 1 otherwise.
- Exactly one of the five state strobes (detectadd, lfdstate, ldstate, fullstate, lafstate) is high in its own state; none is high in WAIT_TILL_EMPTY, LOAD_PARITY or CHECK_PARITY_ERROR.
- Latency:
  - Header accepted with an empty FIFO: lfdstate high on the cycle after the header.
  - Short packet (header, 1 payload, parity): the FSM is back in DECODE_ADDRESS 5 cycles after the header.
- Reset mid-packet: state returns to DECODE_ADDRESS immediately. writeenbreg and busy drop asynchronously.

Decomposition:
- Shared package router_pkg holds:
  - the state encoding localparams (8 states, 3-bit binary);
  - address constants ADDR0..ADDR2 and ADDR_INVALID=3.
- No sub-module; a single module is natural.

Test Plan:
- Reset with rst=0 mid-LOAD_DATA -> detectadd=1, busy=0, writeenbreg=0, rstintreg=0 immediately. rstintreg=1 after release.
- Header din=1, fifoempty1=1, then 3 payload bytes, then pktvalid=0 -> state sequence: LFD one cycle, LOAD_DATA three cycles, LOAD_PARITY, CHECK_PARITY_ERROR (rstintreg=0), DECODE_ADDRESS.
- Header din=2 with fifoempty2=0 for 4 cycles, then 1 -> busy=1 in WAIT_TILL_EMPTY for 4 cycles, then lfdstate=1. Toggling fifoempty0 during the wait has no effect.
- fifofull=1 during LOAD_DATA for 3 cycles -> fullstate=1 for 3 cycles, writeenbreg=0, busy=1. Then lafstate=1. With paritydone=0 and lowpktvalid=0 -> LOAD_DATA.
- In LOAD_AFTER_FULL with lowpktvalid=1 -> LOAD_PARITY. Repeat with paritydone=1 -> DECODE_ADDRESS.
- Header din=3 -> stays in DECODE_ADDRESS, addrq unchanged. softrst0=1 in LOAD_DATA with addrq=0 -> DECODE_ADDRESS next cycle. softrst1=1 with addrq=0 is ignored.
